parking_lot_manager: RTL

- Parametrised successor to the fixed 3-spot parking-lot controller/datapath pair.
- Owns the occupancy count, the entrance and exit gate control, and the hour-of-day tracking.
- Detects the rush window: the first hour the lot fills, and the first hour it then empties.
- Logs per-hour entry counts in a small readable history. Sits between the synchronised GPIO sensor inputs and the HEX/LED display logic.

---
 rtl/parking_lot_manager_pkg.sv | 12 +
 rtl/parking_lot_manager_gate_fsm.sv | 46 ++++
 rtl/parking_lot_manager.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/parking_lot_manager_pkg.sv
// Shared types for the parking-lot manager: day and gate state encodings,
// plus the index of each direction in the per-gate vectors.
package parking_pkg;

  typedef enum logic {DAY_RUN, DAY_END} day_state_t;
  typedef enum logic {G_IDLE, G_OPEN} gate_state_t;

  localparam int N_GATES  = 2;
  localparam int GATE_IN  = 0;
  localparam int GATE_OUT = 1;

endpackage

// File: rtl/parking_lot_manager_gate_fsm.sv
// One gate: opens on sensor && allow, closes when the sensor falls and
// reports the completed passage as a one-cycle pulse.
module gate_fsm
  import parking_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic sensor,
  input  logic allow,
  output logic open,
  output logic passed
);

  gate_state_t state_q, state_d;
  logic        passed_q, passed_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= G_IDLE;
      passed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      passed_q <= passed_d;
    end
  end

  // allow only matters while closed; an open gate waits for the car to clear
  always_comb begin
    state_d  = state_q;
    passed_d = 1'b0;
    unique case (state_q)
      G_IDLE: if (sensor && allow) state_d = G_OPEN;
      G_OPEN: if (!sensor) begin
        state_d  = G_IDLE;
        passed_d = 1'b1;
      end
      default: state_d = G_IDLE;
    endcase
  end

  always_comb begin
    open   = (state_q == G_OPEN);
    passed = passed_q;
  end

endmodule

// File: rtl/parking_lot_manager.sv
// Parking-lot manager: occupancy count, entrance/exit gates, hour-of-day
// tracking, rush-window detection and a per-hour entry history.
module parking_lot_manager
  import parking_pkg::*;
#(
  parameter int N_SPOTS = 3,
  parameter int N_HOURS = 8,
  parameter int ENT_W   = 4,
  parameter int CNT_W   = $clog2(N_SPOTS + 1),
  parameter int HR_W    = $clog2(N_HOURS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter_s,
  input  logic             exit_s,
  input  logic             hour_inc,
  input  logic [HR_W-1:0]  rd_addr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             gate_in,
  output logic             gate_out,
  output logic [HR_W-1:0]  hour,
  output logic             day_over,
  output logic [HR_W-1:0]  rush_start,
  output logic             rush_start_vld,
  output logic [HR_W-1:0]  rush_end,
  output logic             rush_end_vld,
  output logic [ENT_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SPOTS);
  localparam logic [HR_W-1:0]  LAST_HR  = HR_W'(N_HOURS - 1);

  day_state_t       day_q, day_d;
  logic [HR_W-1:0]  hour_q, hour_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [HR_W-1:0]  rush_start_q, rush_start_d, rush_end_q, rush_end_d;
  logic             rush_start_vld_q, rush_start_vld_d;
  logic             rush_end_vld_q, rush_end_vld_d;
  logic [ENT_W-1:0] hist_q [N_HOURS];
  logic [ENT_W-1:0] hist_d [N_HOURS];

  logic [N_GATES-1:0] sensor_v, allow_v, open_v, passed_v;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign sensor_v = {exit_s, enter_s};
  assign allow_v  = {!empty, !full && (day_q == DAY_RUN)};

  for (genvar g = 0; g < N_GATES; g++) begin : g_gate
    gate_fsm u_gate (
      .clock  (clock),
      .reset  (reset),
      .sensor (sensor_v[g]),
      .allow  (allow_v[g]),
      .open   (open_v[g]),
      .passed (passed_v[g])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      day_q            <= DAY_RUN;
      hour_q           <= '0;
      count_q          <= '0;
      rush_start_q     <= '0;
      rush_end_q       <= '0;
      rush_start_vld_q <= 1'b0;
      rush_end_vld_q   <= 1'b0;
      for (int i = 0; i < N_HOURS; i++) hist_q[i] <= '0;
    end else begin
      day_q            <= day_d;
      hour_q           <= hour_d;
      count_q          <= count_d;
      rush_start_q     <= rush_start_d;
      rush_end_q       <= rush_end_d;
      rush_start_vld_q <= rush_start_vld_d;
      rush_end_vld_q   <= rush_end_vld_d;
      for (int i = 0; i < N_HOURS; i++) hist_q[i] <= hist_d[i];
    end
  end

  // Day FSM next state; the last hour holds once the day has ended
  always_comb begin
    day_d  = day_q;
    hour_d = hour_q;
    unique case (day_q)
      DAY_RUN: if (hour_inc) begin
        if (hour_q == LAST_HR) day_d  = DAY_END;
        else                   hour_d = hour_q + 1'b1;
      end
      DAY_END: ;
      default: day_d = DAY_RUN;
    endcase
  end

  always_comb begin
    day_over = (day_q == DAY_END);
  end

  always_comb begin
    count_d = count_q;
    unique case ({passed_v[GATE_OUT], passed_v[GATE_IN]})
      2'b01:   if (count_q != FULL_CNT) count_d = count_q + 1'b1;
      2'b10:   if (count_q != '0)       count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // Rush latches use the hour current while the new count is being written
  always_comb begin
    rush_start_d     = rush_start_q;
    rush_end_d       = rush_end_q;
    rush_start_vld_d = rush_start_vld_q;
    rush_end_vld_d   = rush_end_vld_q;
    if (count_d == FULL_CNT && count_q != FULL_CNT && !rush_start_vld_q) begin
      rush_start_d     = hour_q;
      rush_start_vld_d = 1'b1;
    end else if (count_d == '0 && count_q != '0 && rush_start_vld_q && !rush_end_vld_q) begin
      rush_end_d     = hour_q;
      rush_end_vld_d = 1'b1;
    end
  end

  always_comb begin
    hist_d = hist_q;
    if (passed_v[GATE_IN] && hist_q[hour_q] != '1)
      hist_d[hour_q] = hist_q[hour_q] + 1'b1;
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < (HR_W + 1)'(N_HOURS)) rd_data = hist_q[rd_addr];
  end

  assign count          = count_q;
  assign gate_in        = open_v[GATE_IN];
  assign gate_out       = open_v[GATE_OUT];
  assign hour           = hour_q;
  assign rush_start     = rush_start_q;
  assign rush_start_vld = rush_start_vld_q;
  assign rush_end       = rush_end_q;
  assign rush_end_vld   = rush_end_vld_q;

endmodule
